// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: state register plus combinational decode of
// datapath selects and write enables for lw/sw/R/I-ALU/beq/jal.
module multicycle_control #(
  parameter logic EN_MEM_WAIT = 1'b1,
  parameter logic EN_JAL      = 1'b1,
  parameter logic TRAP_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_ctrl,
  output logic        reg_write,
  output logic [3:0]  state,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      state_r;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        ready_s;
  logic        pc_write_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;
  logic        unused_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign ready_s  = EN_MEM_WAIT ? mem_ready : 1'b1;
  assign unused_s = ^{instr[31], instr[29:15], instr[11:7]};

  // sub is only meaningful for register-register ops; addi never subtracts
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // State register and next-state sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:    state_r <= ready_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode_s)
            OP_LW, OP_SW: state_r <= S_MEMADR;
            OP_R:         state_r <= S_EXECR;
            OP_I:         state_r <= S_EXECI;
            OP_BEQ:       state_r <= S_BRANCH;
            OP_JAL:       state_r <= EN_JAL ? S_JAL : S_TRAP;
            default:      state_r <= S_TRAP;
          endcase
        end
        S_MEMADR:   state_r <= (opcode_s == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state_r <= ready_s ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state_r <= S_FETCH;
        S_MEMWRITE: state_r <= ready_s ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state_r <= S_ALUWB;
        S_EXECI:    state_r <= S_ALUWB;
        S_ALUWB:    state_r <= S_FETCH;
        S_BRANCH:   state_r <= S_FETCH;
        S_JAL:      state_r <= S_ALUWB;
        S_TRAP:     state_r <= TRAP_STICKY ? S_TRAP : S_FETCH;
        default:    state_r <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath selects and raw enables
  always_comb begin
    pc_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_ctrl    = 3'b000;
    case (state_r)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = ready_s;
        pc_write_s = ready_s;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode_s == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_read_s = 1'b1;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_decode(funct3_s, instr[30]);
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_decode(funct3_s, 1'b0);
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = 3'b001;
        pc_write_s = eq;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_s = 1'b1;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // Reset overrides enables immediately, before the state register settles
  assign pc_write  = pc_write_s  & rst_n;
  assign mem_read  = mem_read_s  & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign reg_write = reg_write_s & rst_n;
  assign illegal   = illegal_s   & rst_n;
  assign state     = state_r;

endmodule
